// File: rtl/icap_reboot_ctrl.sv
// ICAP MultiBoot reboot sequencer: issues a 20-byte REBOOT stream to a run-time flash address.
// Optional MB_UNLOCK_EN: start is accepted only with the matching unlock key; err flags rejects.
module icap_reboot_ctrl #(
    parameter int unsigned DIV         = 3,
    parameter logic [7:0]  READ_OPCODE = 8'h0B,
    parameter logic [15:0] UNLOCK_KEY  = 16'hA5C3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] target_addr,
    input  logic [15:0] key_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        icap_clk,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [7:0]  icap_i
);

    localparam int unsigned    PW        = $clog2(16);
    localparam logic [PW-1:0]  LAST_PH   = PW'(DIV - 1);
    localparam logic [4:0]     LAST_BYTE = 5'd19;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t         r_state;
    logic [4:0]     r_byte;
    logic [PW-1:0]  r_phase;
    logic [23:0]    r_addr;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic           r_clk;
    logic           r_en_n;
    logic [7:0]     r_data;

    state_t         w_state_nxt;
    logic [4:0]     w_byte_nxt;
    logic [PW-1:0]  w_phase_nxt;
    logic [23:0]    w_addr_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic           w_err_nxt;
    logic           w_clk_nxt;
    logic           w_en_n_nxt;
    logic [7:0]     w_data_nxt;
    logic [4:0]     w_byte_inc;
    logic           w_key_ok;

`ifdef MB_UNLOCK_EN
    assign w_key_ok = (key_in == UNLOCK_KEY);
`else
    logic w_unused;
    assign w_key_ok = 1'b1;
    assign w_unused = ^{key_in, UNLOCK_KEY};
`endif

    assign w_byte_inc = r_byte + 5'd1;

    // Command stream byte for a given index
    function automatic logic [7:0] f_byte(input logic [4:0] idx,
                                          input logic [23:0] a);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            5'd2:    b = 8'hAA;
            5'd3:    b = 8'h99;
            5'd4:    b = 8'h32;
            5'd5:    b = 8'h61;
            5'd6:    b = a[15:8];
            5'd7:    b = a[7:0];
            5'd8:    b = 8'h32;
            5'd9:    b = 8'h81;
            5'd10:   b = READ_OPCODE;
            5'd11:   b = a[23:16];
            5'd12:   b = 8'h30;
            5'd13:   b = 8'hA1;
            5'd15:   b = 8'h0E;
            5'd16:   b = 8'h20;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ICAP data pins take the byte MSB on bit 0
    function automatic logic [7:0] f_rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Preamble/postamble bytes are clocked with the port deselected
    function automatic logic f_en_n(input logic [4:0] idx);
        return !((idx >= 5'd2) && (idx <= 5'd17));
    endfunction

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_phase_nxt = r_phase;
        w_addr_nxt  = r_addr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_clk_nxt   = 1'b0;
        w_en_n_nxt  = r_en_n;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                w_en_n_nxt = 1'b1;
                w_data_nxt = 8'h00;
                if (start) begin
                    if (w_key_ok) begin
                        w_state_nxt = S_RUN;
                        w_byte_nxt  = 5'd0;
                        w_phase_nxt = '0;
                        w_addr_nxt  = target_addr;
                        w_busy_nxt  = 1'b1;
                        w_en_n_nxt  = f_en_n(5'd0);
                        w_data_nxt  = f_rev(f_byte(5'd0, target_addr));
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (r_phase == LAST_PH) begin
                    w_phase_nxt = '0;
                    if (r_byte == LAST_BYTE) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                        w_en_n_nxt  = 1'b1;
                        w_data_nxt  = 8'h00;
                    end else begin
                        w_byte_nxt = w_byte_inc;
                        w_en_n_nxt = f_en_n(w_byte_inc);
                        w_data_nxt = f_rev(f_byte(w_byte_inc, r_addr));
                    end
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                    w_clk_nxt   = (r_phase == '0);
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_byte_nxt  = 5'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_en_n_nxt  = 1'b1;
                w_data_nxt  = 8'h00;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_byte  <= 5'd0;
            r_phase <= '0;
            r_addr  <= 24'h000000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_clk   <= 1'b0;
            r_en_n  <= 1'b1;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_byte  <= w_byte_nxt;
            r_phase <= w_phase_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_clk   <= w_clk_nxt;
            r_en_n  <= w_en_n_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign icap_clk     = r_clk;
    assign icap_ce_n    = r_en_n;
    assign icap_write_n = r_en_n;
    assign icap_i       = r_data;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// Bench for icap_reboot_ctrl: DIV=3 and DIV=5 instances share stimulus and
// are compared against a timing/byte-stream model derived from the command format.
module tb_icap_reboot_ctrl;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [23:0]     target_addr;
    logic [15:0]     key_in;
    logic [1:0]      busy;
    logic [1:0]      done;
    logic [1:0]      err;
    logic [1:0]      icap_clk;
    logic [1:0]      ce_n;
    logic [1:0]      we_n;
    logic [1:0][7:0] icap_i;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int free_e [2] = '{0, 0};

    int          exp_edge [2][$];
    logic [23:0] exp_addr [2][$];
    int          exp_err  [2][$];

    int          rise_edge [2][$];
    logic [7:0]  rise_raw  [2][$];
    logic        rise_ce   [2][$];
    logic        rise_we   [2][$];
    int          brise     [2][$];
    int          bfall     [2][$];
    int          dedge     [2][$];
    int          eedge     [2][$];
    int          stab_bad  [2];
    logic        pend      [2];
    logic        p_clk     [2];
    logic        p_busy    [2];
    logic        p_ce      [2];
    logic        p_we      [2];
    logic [7:0]  p_i       [2];

    icap_reboot_ctrl #(.DIV(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .target_addr(target_addr), .key_in(key_in),
        .busy(busy[0]), .done(done[0]), .err(err[0]),
        .icap_clk(icap_clk[0]), .icap_ce_n(ce_n[0]),
        .icap_write_n(we_n[0]), .icap_i(icap_i[0])
    );

    icap_reboot_ctrl #(.DIV(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .target_addr(target_addr), .key_in(key_in),
        .busy(busy[1]), .done(done[1]), .err(err[1]),
        .icap_clk(icap_clk[1]), .icap_ce_n(ce_n[1]),
        .icap_write_n(we_n[1]), .icap_i(icap_i[1])
    );

    always #5 clk = ~clk;

    function automatic int div_of(input int d);
        return (d == 0) ? 3 : 5;
    endfunction

    function automatic logic key_ok();
`ifdef MB_UNLOCK_EN
        return (key_in == 16'hA5C3);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input logic [23:0] a);
        logic [7:0] t [20];
        t = '{8'h00, 8'h00, 8'hAA, 8'h99, 8'h32, 8'h61, a[15:8], a[7:0],
              8'h32, 8'h81, 8'h0B, a[23:16], 8'h30, 8'hA1, 8'h00, 8'h0E,
              8'h20, 8'h00, 8'h00, 8'h00};
        return t[k];
    endfunction

    // Reference model: a start is taken once the previous sequence is fully retired
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                free_e[d] <= 0;
            end else if (start && (edge_cnt + 1 >= free_e[d])) begin
                if (key_ok()) begin
                    exp_edge[d].push_back(edge_cnt + 1);
                    exp_addr[d].push_back(target_addr);
                    free_e[d] <= edge_cnt + 1 + 2 + 20 * div_of(d);
                end else begin
                    exp_err[d].push_back(edge_cnt + 1);
                end
            end
        end
    end

    // Monitor: log ICAP clock rises, handshake events and data stability
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (icap_clk[d] && !p_clk[d]) begin
                rise_edge[d].push_back(edge_cnt);
                rise_raw[d].push_back(icap_i[d]);
                rise_ce[d].push_back(ce_n[d]);
                rise_we[d].push_back(we_n[d]);
                if (icap_i[d] !== p_i[d] || ce_n[d] !== p_ce[d] || we_n[d] !== p_we[d])
                    stab_bad[d] = stab_bad[d] + 1;
                pend[d] = 1'b1;
            end else if (pend[d]) begin
                if (icap_i[d] !== p_i[d] || ce_n[d] !== p_ce[d] || we_n[d] !== p_we[d])
                    stab_bad[d] = stab_bad[d] + 1;
                pend[d] = 1'b0;
            end
            if (busy[d] && !p_busy[d]) brise[d].push_back(edge_cnt);
            if (!busy[d] && p_busy[d]) bfall[d].push_back(edge_cnt);
            if (done[d]) dedge[d].push_back(edge_cnt);
            if (err[d]) eedge[d].push_back(edge_cnt);
            p_clk[d]  = icap_clk[d];
            p_busy[d] = busy[d];
            p_ce[d]   = ce_n[d];
            p_we[d]   = we_n[d];
            p_i[d]    = icap_i[d];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            exp_edge[d].delete();
            exp_addr[d].delete();
            exp_err[d].delete();
            rise_edge[d].delete();
            rise_raw[d].delete();
            rise_ce[d].delete();
            rise_we[d].delete();
            brise[d].delete();
            bfall[d].delete();
            dedge[d].delete();
            eedge[d].delete();
            stab_bad[d] = 0;
            pend[d] = 1'b0;
        end
    endtask

    task automatic chk_reset(input string t);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d busy", t, d), busy[d], 1'b0);
            chk($sformatf("%s d%0d done", t, d), done[d], 1'b0);
            chk($sformatf("%s d%0d err", t, d), err[d], 1'b0);
            chk($sformatf("%s d%0d icap_clk", t, d), icap_clk[d], 1'b0);
            chk($sformatf("%s d%0d ce_n", t, d), ce_n[d], 1'b1);
            chk($sformatf("%s d%0d we_n", t, d), we_n[d], 1'b1);
            chk($sformatf("%s d%0d icap_i", t, d), icap_i[d], 8'h00);
        end
    endtask

    task automatic pulse(input logic [23:0] a);
        @(negedge clk);
        start = 1'b1;
        target_addr = a;
        @(negedge clk);
        start = 1'b0;
        target_addr = 24'($urandom);
    endtask

    task automatic drain();
        int lim;
        lim = ((free_e[0] > free_e[1]) ? free_e[0] : free_e[1]) + 3;
        for (int i = 0; i < 3000 && edge_cnt < lim; i++) @(negedge clk);
        chk("drain idle", busy, 2'b00);
    endtask

    task automatic verify(input string t);
        for (int d = 0; d < 2; d++) begin
            int dv;
            int n;
            dv = div_of(d);
            n  = exp_edge[d].size();
            chk($sformatf("%s d%0d nseq", t, d), brise[d].size(), n);
            chk($sformatf("%s d%0d ndone", t, d), dedge[d].size(), n);
            chk($sformatf("%s d%0d nfall", t, d), bfall[d].size(), n);
            chk($sformatf("%s d%0d npulse", t, d), rise_edge[d].size(), 20 * n);
            chk($sformatf("%s d%0d nerr", t, d), eedge[d].size(), exp_err[d].size());
            chk($sformatf("%s d%0d stable", t, d), stab_bad[d], 0);
            for (int s = 0; s < n; s++) begin
                int e;
                e = exp_edge[d][s];
                if (s < brise[d].size())
                    chk($sformatf("%s d%0d s%0d busy_rise", t, d, s), brise[d][s], e);
                if (s < dedge[d].size())
                    chk($sformatf("%s d%0d s%0d done_at", t, d, s), dedge[d][s], e + 20 * dv);
                if (s < bfall[d].size())
                    chk($sformatf("%s d%0d s%0d busy_fall", t, d, s), bfall[d][s], e + 1 + 20 * dv);
                for (int k = 0; k < 20; k++) begin
                    int idx;
                    logic [7:0] b;
                    logic en_n;
                    idx = 20 * s + k;
                    if (idx < rise_edge[d].size()) begin
                        b = {<<{rise_raw[d][idx]}};
                        en_n = !(k >= 2 && k <= 17);
                        chk($sformatf("%s d%0d s%0d k%0d clk_at", t, d, s, k),
                            rise_edge[d][idx], e + 1 + k * dv);
                        chk($sformatf("%s d%0d s%0d k%0d byte", t, d, s, k),
                            b, exp_byte(k, exp_addr[d][s]));
                        chk($sformatf("%s d%0d s%0d k%0d ce_n", t, d, s, k), rise_ce[d][idx], en_n);
                        chk($sformatf("%s d%0d s%0d k%0d we_n", t, d, s, k), rise_we[d][idx], en_n);
                    end
                end
            end
            for (int i = 0; i < eedge[d].size() && i < exp_err[d].size(); i++)
                chk($sformatf("%s d%0d err%0d at", t, d, i), eedge[d][i], exp_err[d][i]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        target_addr = 24'h000000;
        key_in = 16'hA5C3;
        for (int d = 0; d < 2; d++) begin
            stab_bad[d] = 0;
            pend[d] = 1'b0;
            p_clk[d] = 1'b0;
            p_busy[d] = 1'b0;
            p_ce[d] = 1'b1;
            p_we[d] = 1'b1;
            p_i[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        clear_logs();

        pulse(24'h123456);
        drain();
        for (int d = 0; d < 2; d++) begin
            if (rise_raw[d].size() > 3) begin
                chk($sformatf("bitorder d%0d AA", d), rise_raw[d][2], 8'h55);
                chk($sformatf("bitorder d%0d 99", d), rise_raw[d][3], 8'h99);
            end else begin
                chk($sformatf("bitorder d%0d pulses", d), rise_raw[d].size(), 20);
            end
        end
        verify("basic");
        clear_logs();

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse(24'($urandom));
            drain();
            verify($sformatf("rand%0d", i));
            clear_logs();
        end

        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            target_addr = 24'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        chk("hold d0 seqs", brise[0].size(), 2);
        chk("hold d1 seqs", brise[1].size(), 1);
        verify("hold");
        clear_logs();

        pulse(24'($urandom));
        if (exp_edge[0].size() > 0) begin
            int tgt;
            tgt = exp_edge[0][0] + 28;
            for (int i = 0; i < 200 && edge_cnt < tgt; i++) @(negedge clk);
            chk("midrst d0 busy before", busy[0], 1'b1);
        end else begin
            chk("midrst accepted", exp_edge[0].size(), 1);
        end
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        pulse(24'h0A0000);
        drain();
        verify("after_rst");
        clear_logs();

`ifdef MB_UNLOCK_EN
        @(negedge clk);
        key_in = 16'h0000;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        key_in = 16'hA5C3;
        repeat (5) @(negedge clk);
        chk("badkey errs d0", eedge[0].size(), 3);
        verify("badkey");
        clear_logs();
        pulse(24'h3C5A69);
        drain();
        verify("goodkey");
        clear_logs();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
